// File: rtl/tensor_operand_collector_pkg.sv
// Shared constants, operand-select encoding and width helper for the
// tensor operand collector.
package tensor_pkg;

    localparam int DEFAULT_XLEN              = 32;
    localparam int DEFAULT_THREAD_GROUP_SIZE = 4;
    localparam int DEFAULT_NUM_THREAD_GROUPS = 4;
    localparam int DEFAULT_NUM_WARPS         = 4;

    typedef enum logic {
        OP_A = 1'b0,
        OP_B = 1'b1
    } op_sel_e;

    // Index width that stays at least one bit wide for a single warp.
    function automatic int wid_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/tensor_operand_collector_if.sv
// Beat input channel and operand-set output channel of the collector.
interface tensor_operand_collector_if import tensor_pkg::*; #(
    parameter int THREAD_GROUP_SIZE = DEFAULT_THREAD_GROUP_SIZE,
    parameter int NUM_THREAD_GROUPS = DEFAULT_NUM_THREAD_GROUPS,
    parameter int NUM_WARPS         = DEFAULT_NUM_WARPS,
    parameter int XLEN              = DEFAULT_XLEN
) ();

    localparam int ROW_W = THREAD_GROUP_SIZE * XLEN;
    localparam int WID_W = wid_width(NUM_WARPS);

    logic                               in_valid;
    logic                               in_ready;
    logic [WID_W-1:0]                   in_wid;
    logic                               in_sel;
    logic                               in_fmt;
    logic [ROW_W-1:0]                   in_data;
    logic                               out_valid;
    logic                               out_ready;
    logic [WID_W-1:0]                   out_wid;
    logic                               out_fmt;
    logic [ROW_W-1:0]                   out_a;
    logic [NUM_THREAD_GROUPS*ROW_W-1:0] out_b;

    modport master (
        output in_valid, in_wid, in_sel, in_fmt, in_data, out_ready,
        input  in_ready, out_valid, out_wid, out_fmt, out_a, out_b
    );

    modport slave (
        input  in_valid, in_wid, in_sel, in_fmt, in_data, out_ready,
        output in_ready, out_valid, out_wid, out_fmt, out_a, out_b
    );

endinterface

// File: rtl/tensor_operand_collector_rr_arbiter.sv
// Combinational round-robin pick among requesting warps, starting the
// search at the pointer and wrapping around.
module tensor_rr_arbiter import tensor_pkg::*; #(
    parameter int NUM_WARPS = DEFAULT_NUM_WARPS
) (
    input  logic [NUM_WARPS-1:0]            i_req,
    input  logic [wid_width(NUM_WARPS)-1:0] i_ptr,
    output logic [NUM_WARPS-1:0]            o_grant,
    output logic [wid_width(NUM_WARPS)-1:0] o_idx,
    output logic                            o_valid
);

    localparam int WID_W = wid_width(NUM_WARPS);

    int w_cand;

    // First requester at or after the pointer wins.
    always_comb begin
        o_grant = '0;
        o_idx   = '0;
        o_valid = 1'b0;
        w_cand  = 0;
        for (int i = 0; i < NUM_WARPS; i++) begin
            w_cand = (int'(i_ptr) + i) % NUM_WARPS;
            if (!o_valid && i_req[w_cand]) begin
                o_valid         = 1'b1;
                o_grant[w_cand] = 1'b1;
                o_idx           = WID_W'(w_cand);
            end else begin
                o_valid = o_valid;
            end
        end
    end

endmodule

// File: rtl/tensor_operand_collector.sv
// Collects one A row and NUM_THREAD_GROUPS B rows per warp and issues
// complete operand sets round-robin through a registered output stage.
module tensor_operand_collector import tensor_pkg::*; #(
    parameter int THREAD_GROUP_SIZE = DEFAULT_THREAD_GROUP_SIZE,
    parameter int NUM_THREAD_GROUPS = DEFAULT_NUM_THREAD_GROUPS,
    parameter int NUM_WARPS         = DEFAULT_NUM_WARPS,
    parameter int XLEN              = DEFAULT_XLEN
) (
    input  logic                           clk,
    input  logic                           reset,
    tensor_operand_collector_if.slave      bus
);

    localparam int ROW_W = THREAD_GROUP_SIZE * XLEN;
    localparam int WID_W = wid_width(NUM_WARPS);
    localparam int CNT_W = $clog2(NUM_THREAD_GROUPS + 1);
    localparam logic [CNT_W-1:0] B_FULL = CNT_W'(NUM_THREAD_GROUPS);

    logic [NUM_WARPS-1:0]               r_a_done;
    logic [CNT_W-1:0]                   r_b_cnt [NUM_WARPS];
    logic [NUM_WARPS-1:0]               r_fmt;
    logic [ROW_W-1:0]                   r_a_data [NUM_WARPS];
    logic [ROW_W-1:0]                   r_b_data [NUM_WARPS][NUM_THREAD_GROUPS];
    logic [WID_W-1:0]                   r_ptr;
    logic                               r_out_valid;
    logic [WID_W-1:0]                   r_out_wid;
    logic                               r_out_fmt;
    logic [ROW_W-1:0]                   r_out_a;
    logic [NUM_THREAD_GROUPS*ROW_W-1:0] r_out_b;

    logic                               w_in_ready;
    logic                               w_accept;
    logic                               w_acc_a;
    logic                               w_acc_b;
    logic                               w_handshake;
    logic                               w_load;
    logic [NUM_WARPS-1:0]               w_hit;
    logic [NUM_WARPS-1:0]               w_a_done_nxt;
    logic [CNT_W-1:0]                   w_b_cnt_nxt [NUM_WARPS];
    logic [NUM_WARPS-1:0]               w_fmt_nxt;
    logic [ROW_W-1:0]                   w_a_data_nxt [NUM_WARPS];
    logic [ROW_W-1:0]                   w_b_data_nxt [NUM_WARPS][NUM_THREAD_GROUPS];
    logic [NUM_WARPS-1:0]               w_req;
    logic [WID_W-1:0]                   w_ptr_nxt;
    logic [NUM_WARPS-1:0]               w_grant;
    logic [WID_W-1:0]                   w_grant_idx;
    logic                               w_grant_valid;
    logic                               w_out_fmt_nxt;
    logic [NUM_THREAD_GROUPS*ROW_W-1:0] w_out_b_nxt;

    // Backpressure a beat whose target operand is already full.
    always_comb begin
        w_in_ready = 1'b1;
        case (op_sel_e'(bus.in_sel))
            OP_A:    w_in_ready = !r_a_done[bus.in_wid];
            OP_B:    w_in_ready = (r_b_cnt[bus.in_wid] != B_FULL);
            default: w_in_ready = 1'b1;
        endcase
    end

    assign w_accept    = bus.in_valid && w_in_ready;
    assign w_acc_a     = w_accept && (bus.in_sel == OP_A);
    assign w_acc_b     = w_accept && (bus.in_sel == OP_B);
    assign w_handshake = r_out_valid && bus.out_ready;
    assign w_load      = !r_out_valid || bus.out_ready;

    // Post-edge warp state; arbitrating on it lets a set completed this
    // cycle present next cycle. An issuing warp is full, so it cannot
    // also accept a beat in its handshake cycle.
    always_comb begin
        w_hit = '0;
        for (int w = 0; w < NUM_WARPS; w++) begin
            w_hit[w]        = (bus.in_wid == WID_W'(w));
            w_fmt_nxt[w]    = (w_acc_a && w_hit[w]) ? bus.in_fmt  : r_fmt[w];
            w_a_data_nxt[w] = (w_acc_a && w_hit[w]) ? bus.in_data : r_a_data[w];
            for (int k = 0; k < NUM_THREAD_GROUPS; k++) begin
                w_b_data_nxt[w][k] = (w_acc_b && w_hit[w] && (r_b_cnt[w] == CNT_W'(k)))
                                     ? bus.in_data : r_b_data[w][k];
            end
            if (w_handshake && (r_out_wid == WID_W'(w))) begin
                w_a_done_nxt[w] = 1'b0;
                w_b_cnt_nxt[w]  = '0;
            end else if (w_acc_a && w_hit[w]) begin
                w_a_done_nxt[w] = 1'b1;
                w_b_cnt_nxt[w]  = r_b_cnt[w];
            end else if (w_acc_b && w_hit[w]) begin
                w_a_done_nxt[w] = r_a_done[w];
                w_b_cnt_nxt[w]  = r_b_cnt[w] + CNT_W'(1);
            end else begin
                w_a_done_nxt[w] = r_a_done[w];
                w_b_cnt_nxt[w]  = r_b_cnt[w];
            end
            w_req[w] = w_a_done_nxt[w] && (w_b_cnt_nxt[w] == B_FULL);
        end
    end

    // Pointer moves past the warp that just issued.
    always_comb begin
        if (w_handshake) begin
            if (r_out_wid == WID_W'(NUM_WARPS - 1)) begin
                w_ptr_nxt = '0;
            end else begin
                w_ptr_nxt = r_out_wid + WID_W'(1);
            end
        end else begin
            w_ptr_nxt = r_ptr;
        end
    end

    tensor_rr_arbiter #(
        .NUM_WARPS (NUM_WARPS)
    ) u_arb (
        .i_req   (w_req),
        .i_ptr   (w_ptr_nxt),
        .o_grant (w_grant),
        .o_idx   (w_grant_idx),
        .o_valid (w_grant_valid)
    );

    // Gather the granted warp's B rows into the packed output bus.
    always_comb begin
        w_out_fmt_nxt = |(w_grant & w_fmt_nxt);
        w_out_b_nxt   = '0;
        for (int k = 0; k < NUM_THREAD_GROUPS; k++) begin
            w_out_b_nxt[k*ROW_W +: ROW_W] = w_b_data_nxt[w_grant_idx][k];
        end
    end

    // Control flags, pointer and output register stage.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_a_done    <= '0;
            r_ptr       <= '0;
            r_out_valid <= 1'b0;
            r_out_wid   <= '0;
            r_out_fmt   <= 1'b0;
            r_out_a     <= '0;
            r_out_b     <= '0;
            for (int w = 0; w < NUM_WARPS; w++) begin
                r_b_cnt[w] <= '0;
            end
        end else begin
            r_a_done <= w_a_done_nxt;
            r_ptr    <= w_ptr_nxt;
            for (int w = 0; w < NUM_WARPS; w++) begin
                r_b_cnt[w] <= w_b_cnt_nxt[w];
            end
            if (w_load) begin
                r_out_valid <= w_grant_valid;
                if (w_grant_valid) begin
                    r_out_wid <= w_grant_idx;
                    r_out_fmt <= w_out_fmt_nxt;
                    r_out_a   <= w_a_data_nxt[w_grant_idx];
                    r_out_b   <= w_out_b_nxt;
                end
            end
        end
    end

    // Row storage is intentionally left out of reset; the flags gate it.
    always_ff @(posedge clk) begin
        r_fmt <= w_fmt_nxt;
        for (int w = 0; w < NUM_WARPS; w++) begin
            r_a_data[w] <= w_a_data_nxt[w];
            for (int k = 0; k < NUM_THREAD_GROUPS; k++) begin
                r_b_data[w][k] <= w_b_data_nxt[w][k];
            end
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.out_wid   = r_out_wid;
    assign bus.out_fmt   = r_out_fmt;
    assign bus.out_a     = r_out_a;
    assign bus.out_b     = r_out_b;

endmodule

// File: tb/tb_tensor_operand_collector.sv
// Directed scenarios plus random traffic, compared each cycle against a
// queue-based reference model of the operand collector.
module tb_tensor_operand_collector;
    import tensor_pkg::*;

    localparam int TGS     = DEFAULT_THREAD_GROUP_SIZE;
    localparam int NTG     = DEFAULT_NUM_THREAD_GROUPS;
    localparam int NW      = DEFAULT_NUM_WARPS;
    localparam int XL      = DEFAULT_XLEN;
    localparam int ROW_W   = TGS * XL;
    localparam int OUT_B_W = NTG * ROW_W;
    localparam int WID_W   = wid_width(NW);

    logic clk;
    logic reset;
    int   n_checks;
    int   n_errors;

    tensor_operand_collector_if bus ();

    tensor_operand_collector dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model state
    bit               m_a_done [NW];
    bit               m_fmt    [NW];
    logic [ROW_W-1:0] m_a      [NW];
    logic [ROW_W-1:0] m_b      [NW][$];
    int               m_ptr;
    bit               m_valid;
    int               m_wid;
    bit               m_ofmt;
    logic [ROW_W-1:0] m_oa;
    logic [OUT_B_W-1:0] m_ob;

    task automatic check_eq(input string tag, input logic [OUT_B_W-1:0] act,
                            input logic [OUT_B_W-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    function automatic logic [ROW_W-1:0] pat(input logic [7:0] b);
        return {(ROW_W/8){b}};
    endfunction

    function automatic bit m_ready(input int wid, input bit sel);
        if (!sel) return !m_a_done[wid];
        return m_b[wid].size() != NTG;
    endfunction

    function automatic bit m_complete(input int w);
        return m_a_done[w] && (m_b[w].size() == NTG);
    endfunction

    task automatic model_reset();
        for (int w = 0; w < NW; w++) begin
            m_a_done[w] = 1'b0;
            m_b[w].delete();
        end
        m_ptr = 0; m_valid = 1'b0; m_wid = 0; m_ofmt = 1'b0; m_oa = '0; m_ob = '0;
    endtask

    task automatic model_step(input bit v, input int wid, input bit sel, input bit fmt,
                              input logic [ROW_W-1:0] d, input bit ordy, input bit rst);
        bit acc;
        bit hs;
        int w;
        if (rst) begin
            model_reset();
        end else begin
            acc = v && m_ready(wid, sel);
            hs  = m_valid && ordy;
            if (hs) begin
                m_a_done[m_wid] = 1'b0;
                m_b[m_wid].delete();
                m_ptr = (m_wid + 1) % NW;
            end
            if (acc && !sel) begin
                m_a_done[wid] = 1'b1; m_a[wid] = d; m_fmt[wid] = fmt;
            end else if (acc) begin
                m_b[wid].push_back(d);
            end
            if (!m_valid || ordy) begin
                m_valid = 1'b0;
                for (int i = 0; i < NW; i++) begin
                    w = (m_ptr + i) % NW;
                    if (!m_valid && m_complete(w)) begin
                        m_valid = 1'b1; m_wid = w; m_ofmt = m_fmt[w]; m_oa = m_a[w];
                        for (int k = 0; k < NTG; k++) m_ob[k*ROW_W +: ROW_W] = m_b[w][k];
                    end
                end
            end
        end
    endtask

    // One clock: drive, compare against the model, advance both.
    task automatic cycle(input bit v, input int wid, input bit sel, input bit fmt,
                         input logic [ROW_W-1:0] d, input bit ordy, input bit rst);
        bus.in_valid  = v;
        bus.in_wid    = WID_W'(wid);
        bus.in_sel    = sel;
        bus.in_fmt    = fmt;
        bus.in_data   = d;
        bus.out_ready = ordy;
        reset         = rst;
        #1;
        check_eq("in_ready", OUT_B_W'(bus.in_ready), OUT_B_W'(m_ready(wid, sel)));
        check_eq("out_valid", OUT_B_W'(bus.out_valid), OUT_B_W'(m_valid));
        if (m_valid) begin
            check_eq("out_wid", OUT_B_W'(bus.out_wid), OUT_B_W'(m_wid));
            check_eq("out_fmt", OUT_B_W'(bus.out_fmt), OUT_B_W'(m_ofmt));
            check_eq("out_a", OUT_B_W'(bus.out_a), OUT_B_W'(m_oa));
            check_eq("out_b", bus.out_b, m_ob);
        end
        @(posedge clk);
        model_step(v, wid, sel, fmt, d, ordy, rst);
        @(negedge clk);
    endtask

    task automatic beat(input int wid, input bit sel, input logic [ROW_W-1:0] d,
                        input bit fmt, input bit ordy);
        cycle(1'b1, wid, sel, fmt, d, ordy, 1'b0);
    endtask

    task automatic idle(input int n, input bit ordy);
        for (int i = 0; i < n; i++) cycle(1'b0, 0, 1'b0, 1'b0, '0, ordy, 1'b0);
    endtask

    task automatic fill(input int wid, input logic [7:0] tag, input bit fmt, input bit ordy);
        beat(wid, 1'b0, pat(tag), fmt, ordy);
        for (int k = 0; k < NTG; k++) beat(wid, 1'b1, pat(tag + 8'(k + 1)), 1'b0, ordy);
    endtask

    initial begin
        logic [OUT_B_W-1:0] exp_b;
        n_checks = 0;
        n_errors = 0;
        model_reset();
        @(negedge clk);
        cycle(1'b0, 0, 1'b0, 1'b0, '0, 1'b0, 1'b1);
        cycle(1'b0, 0, 1'b0, 1'b0, '0, 1'b0, 1'b1);
        check_eq("rst_out_valid", OUT_B_W'(bus.out_valid), '0);
        check_eq("rst_out_wid", OUT_B_W'(bus.out_wid), '0);
        check_eq("rst_out_a", OUT_B_W'(bus.out_a), '0);
        check_eq("rst_out_b", bus.out_b, '0);

        // Warp 2 single set, rows must come out in arrival order
        beat(2, 1'b0, pat(8'hA0), 1'b1, 1'b1);
        for (int k = 0; k < NTG; k++) beat(2, 1'b1, pat(8'hB0 + 8'(k)), 1'b0, 1'b1);
        exp_b = {pat(8'hB3), pat(8'hB2), pat(8'hB1), pat(8'hB0)};
        check_eq("w2_valid", OUT_B_W'(bus.out_valid), OUT_B_W'(1));
        check_eq("w2_wid", OUT_B_W'(bus.out_wid), OUT_B_W'(2));
        check_eq("w2_fmt", OUT_B_W'(bus.out_fmt), OUT_B_W'(1));
        check_eq("w2_out_a", OUT_B_W'(bus.out_a), OUT_B_W'(pat(8'hA0)));
        check_eq("w2_out_b", bus.out_b, exp_b);
        idle(2, 1'b1);

        // Second A to a warp already holding one is stalled until issue
        beat(1, 1'b0, pat(8'h11), 1'b0, 1'b0);
        beat(1, 1'b0, pat(8'h22), 1'b1, 1'b0);
        bus.in_valid = 1'b1; bus.in_wid = WID_W'(1); bus.in_sel = 1'b0; #1;
        check_eq("dup_a_ready", OUT_B_W'(bus.in_ready), '0);
        @(negedge clk);
        for (int k = 0; k < NTG; k++) beat(1, 1'b1, pat(8'h30 + 8'(k)), 1'b0, 1'b0);
        idle(1, 1'b0);
        check_eq("dup_a_kept", OUT_B_W'(bus.out_a), OUT_B_W'(pat(8'h11)));
        for (int i = 0; i < 3; i++) beat(1, 1'b0, pat(8'h22), 1'b1, 1'b1);
        idle(2, 1'b0);

        // Three warps pending, then drained back to back
        idle(1, 1'b1);
        fill(0, 8'h40, 1'b0, 1'b0);
        fill(3, 8'h60, 1'b1, 1'b0);
        fill(1, 8'h50, 1'b1, 1'b0);
        idle(6, 1'b1);

        // Output held stable under backpressure
        fill(3, 8'h70, 1'b0, 1'b0);
        idle(5, 1'b0);
        idle(3, 1'b1);

        // Reset in the middle of collection drops the partial set
        beat(0, 1'b0, pat(8'h80), 1'b0, 1'b1);
        beat(0, 1'b1, pat(8'h81), 1'b0, 1'b1);
        beat(0, 1'b1, pat(8'h82), 1'b0, 1'b1);
        cycle(1'b0, 0, 1'b0, 1'b0, '0, 1'b1, 1'b1);
        check_eq("mid_rst_valid", OUT_B_W'(bus.out_valid), '0);
        for (int k = 0; k < NTG; k++) beat(0, 1'b1, pat(8'h90 + 8'(k)), 1'b0, 1'b1);
        idle(2, 1'b1);
        check_eq("mid_rst_no_a", OUT_B_W'(bus.out_valid), '0);
        beat(0, 1'b0, pat(8'h9F), 1'b1, 1'b1);
        idle(3, 1'b1);

        // Interleaved B beats to two warps, A last
        for (int k = 0; k < NTG; k++) begin
            beat(0, 1'b1, pat(8'hC0 + 8'(k)), 1'b0, 1'b0);
            beat(1, 1'b1, pat(8'hD0 + 8'(k)), 1'b0, 1'b0);
        end
        beat(1, 1'b0, pat(8'hDA), 1'b1, 1'b0);
        beat(0, 1'b0, pat(8'hCA), 1'b0, 1'b0);
        idle(4, 1'b1);

        // Random traffic
        for (int i = 0; i < 1500; i++) begin
            cycle(($urandom_range(0, 3) != 0), int'($urandom_range(0, NW - 1)),
                  ($urandom_range(0, 4) != 0), 1'($urandom),
                  {$urandom, $urandom, $urandom, $urandom},
                  ($urandom_range(0, 9) < 7), ($urandom_range(0, 299) == 0));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
